// File: rtl/serial_word_receiver_if.sv
// Bundle of the serial bit stream going into the receiver and the assembled
// word results coming out of it. The bit source drives the master side and
// the receiver sits on the slave side.
interface serial_word_receiver_if #(
   parameter int W = 8
);

   logic         bit_in;
   logic         bit_valid;
   logic         start;
   logic [W-1:0] word_out;
   logic [W-1:0] mag_out;
   logic         neg_out;
   logic         word_valid;
   logic         err;

   modport master (
      output bit_in, bit_valid, start,
      input  word_out, mag_out, neg_out, word_valid, err
   );

   modport slave (
      input  bit_in, bit_valid, start,
      output word_out, mag_out, neg_out, word_valid, err
   );

endinterface

// File: rtl/serial_word_receiver.sv
// Bit-serial receiver for LSB-first two's-complement frames of W bits.
// Assembles the raw word and, in parallel, the two's-complement of the word
// using the serial "copy through the first 1, then invert" rule. On the W-th
// accepted bit the word, its sign and its unsigned magnitude are published
// with a one-cycle word_valid pulse. A start arriving mid-frame aborts the
// partial frame, pulses err and begins a new frame with that bit.
module serial_word_receiver #(
   parameter int W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   serial_word_receiver_if.slave bus
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST_COUNT = CW'(W - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic          seen_one;
   logic [W-1:0]  raw_reg;
   logic [W-1:0]  comp_reg;

   logic          comp_bit;
   logic [W-1:0]  raw_shift;
   logic [W-1:0]  comp_shift;

   // Next values of the two shift registers if the current bit is appended as
   // a continuation bit; new bits enter at the top and move down so that bit 0
   // lands at position 0 after W shifts.
   always_comb begin
      comp_bit   = bus.bit_in;
      if (seen_one) begin
         comp_bit = ~bus.bit_in;
      end
      raw_shift  = {bus.bit_in, raw_reg[W-1:1]};
      comp_shift = {comp_bit, comp_reg[W-1:1]};
   end

   // Frame FSM, shift registers and registered result/pulse outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         count          <= '0;
         seen_one       <= 1'b0;
         raw_reg        <= '0;
         comp_reg       <= '0;
         bus.word_out   <= '0;
         bus.mag_out    <= '0;
         bus.neg_out    <= 1'b0;
         bus.word_valid <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         bus.word_valid <= 1'b0;
         bus.err        <= 1'b0;
         if (bus.bit_valid) begin
            if (bus.start) begin
               if (state == SHIFT) begin
                  bus.err <= 1'b1;
               end
               raw_reg  <= {bus.bit_in, {(W-1){1'b0}}};
               comp_reg <= {bus.bit_in, {(W-1){1'b0}}};
               seen_one <= bus.bit_in;
               count    <= CW'(1);
               state    <= SHIFT;
            end else if (state == SHIFT) begin
               if (count == LAST_COUNT) begin
                  raw_reg        <= raw_shift;
                  comp_reg       <= comp_shift;
                  bus.word_out   <= raw_shift;
                  bus.neg_out    <= bus.bit_in;
                  bus.mag_out    <= bus.bit_in ? comp_shift : raw_shift;
                  bus.word_valid <= 1'b1;
                  seen_one       <= 1'b0;
                  count          <= '0;
                  state          <= IDLE;
               end else begin
                  raw_reg  <= raw_shift;
                  comp_reg <= comp_shift;
                  seen_one <= seen_one | bus.bit_in;
                  count    <= count + CW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Testbench for serial_word_receiver: directed scenarios plus a randomized
// stream, all compared against a frame-level reference model that collects
// accepted bits in a queue and evaluates finished frames arithmetically.
module tb_serial_word_receiver;

   localparam int W    = 8;
   localparam int MASK = (1 << W) - 1;

   logic clk;
   logic rst;

   serial_word_receiver_if #(.W(W)) bus ();

   serial_word_receiver #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic   m_active;
   logic   m_bits[$];
   int     exp_word;
   int     exp_mag;
   int     exp_neg;
   logic   exp_wv;
   logic   exp_err;

   // Observation bookkeeping
   int     cyc;
   int     obs_wv;
   int     obs_err;
   int     wv_cycles[$];

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always terminates
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired before the bench completed");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model reset
   task automatic model_reset();
      m_active = 1'b0;
      m_bits.delete();
      exp_word = 0;
      exp_mag  = 0;
      exp_neg  = 0;
      exp_wv   = 1'b0;
      exp_err  = 1'b0;
   endtask

   // Drive one clock of stimulus, advance the model, and record pulses seen
   task automatic applyStimulus(input logic v, input logic s, input logic b);
      int value;
      @(negedge clk);
      bus.bit_valid = v;
      bus.start     = s;
      bus.bit_in    = b;
      @(posedge clk);
      cyc++;
      exp_wv  = 1'b0;
      exp_err = 1'b0;
      if (v) begin
         if (s) begin
            if (m_active) exp_err = 1'b1;
            m_bits.delete();
            m_bits.push_back(b);
            m_active = 1'b1;
         end else if (m_active) begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
               value = 0;
               for (int i = 0; i < W; i++) value += int'(m_bits[i]) << i;
               exp_word = value;
               exp_neg  = (value >> (W - 1)) & 1;
               exp_mag  = (exp_neg != 0) ? (((1 << W) - value) & MASK) : value;
               exp_wv   = 1'b1;
               m_active = 1'b0;
               m_bits.delete();
            end
         end
      end
      #1;
      if (bus.word_valid === 1'b1) begin
         obs_wv++;
         wv_cycles.push_back(cyc);
      end
      if (bus.err === 1'b1) obs_err++;
   endtask

   task automatic clear_obs();
      obs_wv  = 0;
      obs_err = 0;
      wv_cycles.delete();
   endtask

   // Reset values of every output
   task automatic test_reset();
      rst = 1'b0;
      bus.bit_valid = 1'b0;
      bus.start     = 1'b0;
      bus.bit_in    = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.word_out !== '0) begin
         failures++; $display("[TB] FAIL reset_word_out actual=%0h expected=0", bus.word_out);
      end
      checks++;
      if (bus.mag_out !== '0) begin
         failures++; $display("[TB] FAIL reset_mag_out actual=%0h expected=0", bus.mag_out);
      end
      checks++;
      if (bus.neg_out !== 1'b0 || bus.word_valid !== 1'b0 || bus.err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags actual neg=%b wv=%b err=%b expected all 0",
                  bus.neg_out, bus.word_valid, bus.err);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Single frame 0xF9 with continuous bits
   task automatic test_single_word();
      logic [W-1:0] val;
      int start_cyc;
      val = 8'hF9;
      clear_obs();
      for (int i = 0; i < W; i++) begin
         applyStimulus(1'b1, i == 0, val[i]);
         if (i == 0) start_cyc = cyc;
      end
      checks++;
      if (bus.word_valid !== 1'b1 || obs_wv != 1) begin
         failures++; $display("[TB] FAIL single_wv actual=%b count=%0d expected=1 count=1", bus.word_valid, obs_wv);
      end
      checks++;
      if (bus.word_out !== 8'hF9 || bus.word_out !== exp_word[W-1:0]) begin
         failures++; $display("[TB] FAIL single_word actual=%0h expected=f9", bus.word_out);
      end
      checks++;
      if (bus.mag_out !== 8'h07 || bus.neg_out !== 1'b1) begin
         failures++; $display("[TB] FAIL single_mag actual mag=%0h neg=%b expected mag=7 neg=1", bus.mag_out, bus.neg_out);
      end
      checks++;
      if (wv_cycles.size() != 1 || wv_cycles[0] != start_cyc + W - 1) begin
         failures++; $display("[TB] FAIL single_latency actual=%0d expected=%0d",
                              (wv_cycles.size() > 0) ? wv_cycles[0] - start_cyc : -1, W - 1);
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.word_valid !== 1'b0 || bus.word_out !== 8'hF9) begin
         failures++; $display("[TB] FAIL single_pulse_width actual wv=%b word=%0h expected wv=0 word=f9",
                              bus.word_valid, bus.word_out);
      end
   endtask

   // 0x2A then 0x80 with no gap
   task automatic test_back_to_back();
      logic [2*W-1:0] vals;
      logic [W-1:0]   first_word;
      logic [W-1:0]   first_mag;
      logic           first_neg;
      vals = 16'h802A;
      clear_obs();
      first_word = '0; first_mag = '0; first_neg = 1'b0;
      for (int i = 0; i < 2 * W; i++) begin
         applyStimulus(1'b1, (i % W) == 0, vals[i]);
         if (i == W - 1) begin
            first_word = bus.word_out;
            first_mag  = bus.mag_out;
            first_neg  = bus.neg_out;
         end
      end
      checks++;
      if (first_word !== 8'h2A || first_mag !== 8'h2A || first_neg !== 1'b0) begin
         failures++; $display("[TB] FAIL b2b_first actual word=%0h mag=%0h neg=%b expected 2a 2a 0",
                              first_word, first_mag, first_neg);
      end
      checks++;
      if (bus.word_out !== 8'h80 || bus.mag_out !== 8'h80 || bus.neg_out !== 1'b1 ||
          bus.mag_out !== exp_mag[W-1:0]) begin
         failures++; $display("[TB] FAIL b2b_second actual word=%0h mag=%0h neg=%b expected 80 80 1",
                              bus.word_out, bus.mag_out, bus.neg_out);
      end
      checks++;
      if (obs_wv != 2 || wv_cycles.size() != 2 || (wv_cycles[1] - wv_cycles[0]) != W) begin
         failures++; $display("[TB] FAIL b2b_spacing actual pulses=%0d expected pulses=2 spaced %0d", obs_wv, W);
      end
   endtask

   // 0xFF with bubbles after bits 2 and 5
   task automatic test_bubbles();
      logic [W-1:0] val;
      int start_cyc;
      val = 8'hFF;
      clear_obs();
      for (int i = 0; i < W; i++) begin
         applyStimulus(1'b1, i == 0, val[i]);
         if (i == 0) start_cyc = cyc;
         if (i == 2 || i == 5) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.word_valid !== 1'b0 || bus.err !== 1'b0) begin
               failures++; $display("[TB] FAIL bubble_quiet actual wv=%b err=%b expected 0 0", bus.word_valid, bus.err);
            end
         end
      end
      checks++;
      if (obs_wv != 1 || wv_cycles[0] - start_cyc != W + 1) begin
         failures++; $display("[TB] FAIL bubble_latency actual pulses=%0d expected 1 at offset %0d", obs_wv, W + 1);
      end
      checks++;
      if (bus.mag_out !== 8'h01 || bus.neg_out !== 1'b1 || bus.word_out !== 8'hFF) begin
         failures++; $display("[TB] FAIL bubble_result actual word=%0h mag=%0h neg=%b expected ff 01 1",
                              bus.word_out, bus.mag_out, bus.neg_out);
      end
   endtask

   // Abort after 3 bits, restart with 0x01
   task automatic test_abort();
      logic [W-1:0] prev_word;
      logic [W-1:0] val;
      val = 8'h01;
      prev_word = bus.word_out;
      clear_obs();
      applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < W; i++) begin
         applyStimulus(1'b1, i == 0, val[i]);
         if (i == 0) begin
            checks++;
            if (bus.err !== 1'b1 || bus.word_out !== prev_word || bus.word_valid !== 1'b0) begin
               failures++; $display("[TB] FAIL abort_pulse actual err=%b word=%0h expected err=1 word=%0h",
                                    bus.err, bus.word_out, prev_word);
            end
         end
      end
      checks++;
      if (obs_err != 1 || obs_wv != 1) begin
         failures++; $display("[TB] FAIL abort_counts actual err=%0d wv=%0d expected 1 1", obs_err, obs_wv);
      end
      checks++;
      if (bus.word_out !== 8'h01 || bus.mag_out !== 8'h01 || bus.neg_out !== 1'b0) begin
         failures++; $display("[TB] FAIL abort_result actual word=%0h mag=%0h expected 01 01", bus.word_out, bus.mag_out);
      end
   endtask

   // Start on the completing edge becomes abort plus new frame
   task automatic test_abort_on_last();
      logic [W-1:0] prev_word;
      prev_word = bus.word_out;
      clear_obs();
      for (int i = 0; i < W; i++) applyStimulus(1'b1, (i == 0) || (i == W - 1), 1'b1);
      checks++;
      if (obs_wv != 0 || obs_err != 1 || bus.word_out !== prev_word) begin
         failures++; $display("[TB] FAIL abort_last actual wv=%0d err=%0d word=%0h expected 0 1 %0h",
                              obs_wv, obs_err, bus.word_out, prev_word);
      end
      // finish the frame that the late start began so the model and DUT idle
      for (int i = 1; i < W; i++) applyStimulus(1'b1, 1'b0, 1'b0);
   endtask

   // Reset mid-frame, stray bits, then 0xC3
   task automatic test_reset_mid_frame();
      logic [W-1:0] val;
      val = 8'hC3;
      clear_obs();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, i == 0, val[i]);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (bus.word_out !== '0 || bus.mag_out !== '0 || bus.neg_out !== 1'b0 ||
          bus.word_valid !== 1'b0 || bus.err !== 1'b0) begin
         failures++; $display("[TB] FAIL rst_async actual word=%0h mag=%0h neg=%b expected all 0",
                              bus.word_out, bus.mag_out, bus.neg_out);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 4; i < W; i++) applyStimulus(1'b1, 1'b0, val[i]);
      checks++;
      if (obs_wv != 0 || obs_err != 0) begin
         failures++; $display("[TB] FAIL rst_stray actual wv=%0d err=%0d expected 0 0", obs_wv, obs_err);
      end
      for (int i = 0; i < W; i++) applyStimulus(1'b1, i == 0, val[i]);
      checks++;
      if (bus.mag_out !== 8'h3D || bus.neg_out !== 1'b1 || bus.word_out !== 8'hC3 || obs_wv != 1) begin
         failures++; $display("[TB] FAIL rst_recover actual word=%0h mag=%0h neg=%b expected c3 3d 1",
                              bus.word_out, bus.mag_out, bus.neg_out);
      end
   endtask

   // Bits without start while idle are ignored
   task automatic test_idle_ignore();
      logic [W-1:0] prev_word;
      logic [W-1:0] prev_mag;
      prev_word = bus.word_out;
      prev_mag  = bus.mag_out;
      clear_obs();
      for (int i = 0; i < 2 * W; i++) applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      checks++;
      if (obs_wv != 0 || obs_err != 0 || bus.word_out !== prev_word || bus.mag_out !== prev_mag) begin
         failures++; $display("[TB] FAIL idle_ignore actual wv=%0d err=%0d word=%0h expected 0 0 %0h",
                              obs_wv, obs_err, bus.word_out, prev_word);
      end
   endtask

   // Random stream with bubbles and occasional aborts, checked every cycle
   task automatic test_random();
      logic v, s, b;
      for (int n = 0; n < 600; n++) begin
         v = ($urandom_range(0, 3) != 0);
         s = m_active ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
         b = 1'($urandom_range(0, 1));
         applyStimulus(v, s, b);
         checks++;
         if (bus.word_valid !== exp_wv || bus.err !== exp_err) begin
            failures++; $display("[TB] FAIL rand_pulse cycle=%0d actual wv=%b err=%b expected wv=%b err=%b",
                                 cyc, bus.word_valid, bus.err, exp_wv, exp_err);
         end
         checks++;
         if (bus.word_out !== exp_word[W-1:0] || bus.mag_out !== exp_mag[W-1:0] ||
             bus.neg_out !== exp_neg[0]) begin
            failures++; $display("[TB] FAIL rand_data cycle=%0d actual word=%0h mag=%0h neg=%b expected %0h %0h %0d",
                                 cyc, bus.word_out, bus.mag_out, bus.neg_out, exp_word, exp_mag, exp_neg);
         end
      end
   endtask

   // Scenario sequence
   initial begin
      cyc = 0;
      clear_obs();
      test_reset();
      test_single_word();
      test_back_to_back();
      test_bubbles();
      test_abort();
      test_abort_on_last();
      test_reset_mid_frame();
      test_idle_ignore();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Bit-serial receiver for two's-complement words sent LSB-first, one bit per accepted clock. It sits at the consuming end of the serial datapath, downstream of the serial two's-complement generator and any other LSB-first bit source. It assembles W-bit frames into a parallel word and produces the sign and unsigned magnitude, computed serially as the bits arrive. It also flags frames that were aborted before completion.

## Interface
Parameters:
- W, 8, frame width in bits (W >= 2)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset; clears all state immediately and is released synchronously by the environment
- bit_in  in  1  serial data bit, LSB first
- bit_valid  in  1  bit_in is sampled on this edge; when low the edge is a bubble and nothing advances
- start  in  1  qualified by bit_valid; marks the accepted bit as bit 0 (LSB) of a new frame
- word_out  out  W  last completed frame, raw two's-complement value
- mag_out  out  W  unsigned magnitude of word_out; 2^(W-1) for the most-negative value
- neg_out  out  1  sign of word_out (its MSB)
- word_valid  out  1  one-cycle pulse: word_out, mag_out and neg_out were just updated
- err  out  1  one-cycle pulse: the in-progress frame was aborted by a new start

## Operation
- FSM with two states, IDLE and SHIFT. Reset state is IDLE.
- Bit counter is clog2(W) bits wide and counts accepted bits 0..W-1.
- A bit is accepted on an edge where bit_valid=1 and either start=1 or the FSM is in SHIFT.
- IDLE:
  - bit_valid&start: capture the bit as bit 0, count=1, go to SHIFT.
  - bit_valid&!start: bit is ignored, no error.
- SHIFT:
  - bit_valid&!start: shift the bit in at position count, count+1.
  - On the W-th accepted bit: update outputs, pulse word_valid, go to IDLE.
- Abort: bit_valid&start while in SHIFT.
  - Discard the partial frame and pulse err.
  - The start bit becomes bit 0 of a new frame (count=1, stay in SHIFT).
  - Outputs keep their previous values.
- Serial magnitude uses the Mealy "copy up to and including the first 1, then invert" rule.
  - Track seen_one, cleared at bit 0 of each frame.
  - Complement bit c = seen_one ? ~b : b.
  - Shift the raw bit and c into two W-bit registers in parallel.
- On completion:
  - neg_out = MSB of the raw register (the W-th bit).
  - word_out = raw register.
  - mag_out = neg_out ? complement register : raw register.
- Arithmetic: mag_out is W-bit unsigned, so no overflow is possible.
  - W=8: 0x80 gives mag 0x80.
  - 0x00 gives mag 0x00, neg 0.
- Reset values: word_out=0, mag_out=0, neg_out=0, word_valid=0, err=0, FSM=IDLE, count=0, seen_one=0.

## Timing
- Outputs are registered. word_out, mag_out, neg_out and word_valid change on the edge that samples the W-th bit and are visible the following cycle.
- Latency is 0 extra cycles after the last bit's sampling edge.
- word_valid is high for exactly one clock per completed frame.
- word_out, mag_out and neg_out hold until the next completion or reset.
- err is high for exactly one clock, on the cycle after the aborting edge.
- Bubbles (bit_valid=0) anywhere in a frame:
  - No state change; a frame may stretch arbitrarily.
  - word_valid and err still drop after one cycle.
- Back-to-back frames:
  - The completing edge returns the FSM to IDLE.
  - A start on the very next edge is accepted, so full throughput is one bit per clock with no gap.
- The completing bit never carries start. A start on that edge is treated as an abort plus a new frame, so no word_valid is produced.
- Reset asserted mid-frame:
  - All state and outputs clear asynchronously and no word_valid or err is produced.
  - After release, bits are ignored until a start.

## Test plan
- Reset, then W=8, stream 0xF9 LSB-first (1,0,0,1,1,1,1,1) with start on the first bit, bit_valid=1 continuously -> word_valid pulses once, the cycle after the 8th edge; word_out=0xF9, neg_out=1, mag_out=0x07.
- Stream 0x2A, then 0x80 back-to-back with no idle cycle -> two word_valid pulses 8 cycles apart:
  - first frame: word_out=0x2A, neg=0, mag=0x2A
  - second frame: word_out=0x80, neg=1, mag=0x80
- Stream 0xFF with bit_valid=0 bubbles inserted after bits 2 and 5 -> word_valid 10 cycles after start; mag_out=0x01, neg=1.
- Start a frame, send 3 bits, then assert start with 0x01's LSB -> err pulses once with the previous outputs unchanged; 8 bits later word_out=0x01, mag=0x01.
- Drive rst low after 4 bits of 0xC3 -> outputs=0 immediately. Release rst, send bits with no start -> no word_valid. Then send 0xC3 with start -> mag_out=0x3D, neg=1.
- Send bits with bit_valid=1 and start=0 while IDLE -> no word_valid, no err, outputs unchanged.
